// File: rtl/alu_stim_driver.sv
// -----------------------------------------------------------------------------
// alu_stim_driver
//   Self-sequencing stimulus generator for the 64-bit ALU bench. Walks the ALU
//   opcode table (19 entries). For each opcode it issues N_PER_OP vectors:
//   index 0 is a fixed corner vector, the rest are LFSR-random vectors. Each
//   vector is held until the result checker acknowledges it or a timeout expires.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   srst         synchronous soft reset (same effect as rst_n, taken on clk)
//   start        begin a run (honoured in IDLE only)
//   seed         LFSR seed captured on an accepted start (0 is replaced by 1)
//   ack          checker has consumed the current vector (honoured in WAIT_ACK)
//   opcode/A/B   registered ALU stimulus
//   vec_valid    one-cycle pulse when a new vector first appears
//   sample       high throughout WAIT_ACK (outputs have settled)
//   busy         high from accepted start until DONE
//   done         one-cycle pulse at end of run
//   err_timeout  sticky ack-timeout flag, cleared on accepted start
//   vec_count    vectors completed in the current run (saturating)
// -----------------------------------------------------------------------------
module alu_stim_driver #(
    parameter int N_PER_OP    = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        srst,
    input  logic        start,
    input  logic [63:0] seed,
    input  logic        ack,
    output logic [4:0]  opcode,
    output logic [63:0] A,
    output logic [63:0] B,
    output logic        vec_valid,
    output logic        sample,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic [15:0] vec_count
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_APPLY    = 3'd1,
        ST_HOLD     = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic [4:0]  NUM_OPS   = 5'd19;
    localparam logic [12:0] LAST_VEC  = 13'(N_PER_OP - 1);
    localparam logic [7:0]  LAST_HOLD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0]  LAST_WAIT = 8'(TIMEOUT - 1);
    // x^64+x^63+x^61+x^60+1 as the toggle mask of a right-shifting Galois LFSR
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    // One Galois LFSR step.
    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return s[0] ? ({1'b0, s[63:1]} ^ LFSR_TAPS) : {1'b0, s[63:1]};
    endfunction

    // Opcode table: 00-0E, 10, 11, 12, 14.
    function automatic logic [4:0] op_lookup(input logic [4:0] idx);
        logic [4:0] op;
        case (idx)
            5'd15:   op = 5'h10;
            5'd16:   op = 5'h11;
            5'd17:   op = 5'h12;
            5'd18:   op = 5'h14;
            default: op = (idx < 5'd15) ? idx : 5'h1F;
        endcase
        return op;
    endfunction

    state_t      state_r, state_s;
    logic [4:0]  opcode_r, opcode_s;
    logic [63:0] a_r, a_s, b_r, b_s;
    logic [63:0] lfsr_r, lfsr_s;
    logic        vec_valid_r, vec_valid_s;
    logic        sample_r, sample_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        err_r, err_s;
    logic [15:0] count_r, count_s;
    // op_ptr/vec_ptr name the NEXT vector to be issued; op_ptr == NUM_OPS means none left
    logic [4:0]  op_ptr_r, op_ptr_s;
    logic [12:0] vec_ptr_r, vec_ptr_s;
    logic [7:0]  hold_cnt_r, hold_cnt_s;
    logic [7:0]  wait_cnt_r, wait_cnt_s;

    // Vector-load request and the source it should be built from.
    logic        load_s;
    logic [4:0]  ld_op_s;
    logic [12:0] ld_vec_s;
    logic [63:0] ld_lfsr_s;
    logic [63:0] step1_s, step2_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else if (srst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, control flags, counters and vector-load requests.
    always_comb begin
        state_s    = state_r;
        sample_s   = sample_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        err_s      = err_r;
        count_s    = count_r;
        hold_cnt_s = hold_cnt_r;
        wait_cnt_s = wait_cnt_r;
        load_s     = 1'b0;
        ld_op_s    = op_ptr_r;
        ld_vec_s   = vec_ptr_r;
        ld_lfsr_s  = lfsr_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s    = 1'b1;
                    ld_op_s   = 5'd0;
                    ld_vec_s  = 13'd0;
                    ld_lfsr_s = (seed == 64'd0) ? 64'd1 : seed;
                    err_s     = 1'b0;
                    count_s   = 16'd0;
                    busy_s    = 1'b1;
                    state_s   = ST_APPLY;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_APPLY: begin
                hold_cnt_s = 8'd0;
                state_s    = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_cnt_r == LAST_HOLD) begin
                    wait_cnt_s = 8'd0;
                    sample_s   = 1'b1;
                    state_s    = ST_WAIT_ACK;
                end else begin
                    hold_cnt_s = hold_cnt_r + 8'd1;
                end
            end
            ST_WAIT_ACK: begin
                if (ack || (wait_cnt_r == LAST_WAIT)) begin
                    // A timeout counts as completion so the run always terminates.
                    if (!ack) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = err_r;
                    end
                    if (count_r != 16'hFFFF) begin
                        count_s = count_r + 16'd1;
                    end else begin
                        count_s = count_r;
                    end
                    sample_s = 1'b0;
                    if (op_ptr_r != NUM_OPS) begin
                        load_s  = 1'b1;
                        state_s = ST_APPLY;
                    end else begin
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                        state_s = ST_DONE;
                    end
                end else begin
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                sample_s = 1'b0;
                busy_s   = 1'b0;
                state_s  = ST_IDLE;
            end
        endcase
    end

    // Build the next vector (operands, opcode fix-ups, LFSR and pointer advance).
    always_comb begin
        opcode_s    = opcode_r;
        a_s         = a_r;
        b_s         = b_r;
        lfsr_s      = lfsr_r;
        op_ptr_s    = op_ptr_r;
        vec_ptr_s   = vec_ptr_r;
        vec_valid_s = 1'b0;
        step1_s     = lfsr_step(ld_lfsr_s);
        step2_s     = lfsr_step(step1_s);
        if (load_s) begin
            vec_valid_s = 1'b1;
            opcode_s    = op_lookup(ld_op_s);
            if (ld_vec_s == 13'd0) begin
                // Corner vector leaves the LFSR untouched.
                a_s    = 64'hFFFF_FFFF_FFFF_FFFF;
                b_s    = 64'd1;
                lfsr_s = ld_lfsr_s;
            end else begin
                a_s    = step1_s;
                b_s    = step2_s;
                lfsr_s = step2_s;
            end
            case (opcode_s)
                5'h02, 5'h04, 5'h05: b_s = {58'd0, b_s[5:0]};   // shift amount only
                5'h12, 5'h14: begin                             // never divide by zero
                    if (b_s == 64'd0) begin
                        b_s = 64'd1;
                    end else begin
                        b_s = b_s;
                    end
                end
                5'h0B:   a_s = 64'd0;                           // LUI ignores A
                default: a_s = a_s;
            endcase
            if (ld_vec_s == LAST_VEC) begin
                op_ptr_s  = ld_op_s + 5'd1;
                vec_ptr_s = 13'd0;
            end else begin
                op_ptr_s  = ld_op_s;
                vec_ptr_s = ld_vec_s + 13'd1;
            end
        end else begin
            vec_valid_s = 1'b0;
        end
    end

    // Datapath and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_r    <= 5'h1F;
            a_r         <= 64'd0;
            b_r         <= 64'd0;
            lfsr_r      <= 64'd1;
            vec_valid_r <= 1'b0;
            sample_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            count_r     <= 16'd0;
            op_ptr_r    <= 5'd0;
            vec_ptr_r   <= 13'd0;
            hold_cnt_r  <= 8'd0;
            wait_cnt_r  <= 8'd0;
        end else if (srst) begin
            opcode_r    <= 5'h1F;
            a_r         <= 64'd0;
            b_r         <= 64'd0;
            lfsr_r      <= 64'd1;
            vec_valid_r <= 1'b0;
            sample_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            count_r     <= 16'd0;
            op_ptr_r    <= 5'd0;
            vec_ptr_r   <= 13'd0;
            hold_cnt_r  <= 8'd0;
            wait_cnt_r  <= 8'd0;
        end else begin
            opcode_r    <= opcode_s;
            a_r         <= a_s;
            b_r         <= b_s;
            lfsr_r      <= lfsr_s;
            vec_valid_r <= vec_valid_s;
            sample_r    <= sample_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            err_r       <= err_s;
            count_r     <= count_s;
            op_ptr_r    <= op_ptr_s;
            vec_ptr_r   <= vec_ptr_s;
            hold_cnt_r  <= hold_cnt_s;
            wait_cnt_r  <= wait_cnt_s;
        end
    end

    assign opcode      = opcode_r;
    assign A           = a_r;
    assign B           = b_r;
    assign vec_valid   = vec_valid_r;
    assign sample      = sample_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err_timeout = err_r;
    assign vec_count   = count_r;

endmodule

// File: tb/tb_alu_stim_driver.sv
// -----------------------------------------------------------------------------
// tb_alu_stim_driver
//   Self-checking bench for alu_stim_driver. dut0 uses default parameters,
//   dut1 uses N_PER_OP=2. The expected vector stream is computed from the
//   opcode table and operand rules with plain loops and arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_stim_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        srst;

    logic        start0, ack0;
    logic [63:0] seed0;
    logic [4:0]  opcode0;
    logic [63:0] A0, B0;
    logic        vv0, sample0, busy0, done0, err0;
    logic [15:0] cnt0;

    logic        start1, ack1;
    logic [63:0] seed1;
    logic [4:0]  opcode1;
    logic [63:0] A1, B1;
    logic        vv1, sample1, busy1, done1, err1;
    logic [15:0] cnt1;

    always #5 clk = ~clk;

    alu_stim_driver dut0 (
        .clk(clk), .rst_n(rst_n), .srst(srst), .start(start0), .seed(seed0),
        .ack(ack0), .opcode(opcode0), .A(A0), .B(B0), .vec_valid(vv0),
        .sample(sample0), .busy(busy0), .done(done0), .err_timeout(err0),
        .vec_count(cnt0)
    );

    alu_stim_driver #(.N_PER_OP(2), .HOLD_CYCLES(2), .TIMEOUT(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .srst(srst), .start(start1), .seed(seed1),
        .ack(ack1), .opcode(opcode1), .A(A1), .B(B1), .vec_valid(vv1),
        .sample(sample1), .busy(busy1), .done(done1), .err_timeout(err1),
        .vec_count(cnt1)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Cycle counter, advanced on the active edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed vector log for dut0.
    logic [4:0]  obs_op  [0:1023];
    logic [63:0] obs_a   [0:1023];
    logic [63:0] obs_b   [0:1023];
    int          obs_cyc [0:1023];
    logic        obs_err [0:1023];
    int          nobs = 0;
    int          ndone = 0;
    int          unstable = 0;
    logic [4:0]  cur_op = 5'h1F;
    logic [63:0] cur_a = 64'd0, cur_b = 64'd0;
    logic        prev_vv = 1'b0;

    always @(negedge clk) begin
        if (vv0) begin
            if (nobs < 1024) begin
                obs_op[nobs]  <= opcode0;
                obs_a[nobs]   <= A0;
                obs_b[nobs]   <= B0;
                obs_cyc[nobs] <= cyc;
                obs_err[nobs] <= err0;
            end
            nobs   <= nobs + 1;
            cur_op <= opcode0;
            cur_a  <= A0;
            cur_b  <= B0;
            if (prev_vv) unstable <= unstable + 1;
        end else if (busy0 && (opcode0 !== cur_op || A0 !== cur_a || B0 !== cur_b)) begin
            unstable <= unstable + 1;
        end
        if (done0) ndone <= ndone + 1;
        prev_vv <= vv0;
    end

    // Observed vector log for dut1.
    logic [4:0]  o1_op [0:63];
    logic [63:0] o1_a  [0:63];
    logic [63:0] o1_b  [0:63];
    int          n1 = 0;

    always @(negedge clk) begin
        if (vv1) begin
            if (n1 < 64) begin
                o1_op[n1] <= opcode1;
                o1_a[n1]  <= A1;
                o1_b[n1]  <= B1;
            end
            n1 <= n1 + 1;
        end
    end

    // Reference model: expected vector stream for a seed.
    logic [4:0]  optab [0:18] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06,
                                  5'h07, 5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D,
                                  5'h0E, 5'h10, 5'h11, 5'h12, 5'h14};
    logic [4:0]  exp_op [0:75];
    logic [63:0] exp_a  [0:75];
    logic [63:0] exp_b  [0:75];

    function automatic logic [63:0] gal(input logic [63:0] s);
        logic [63:0] poly;
        poly = (64'd1 << 63) | (64'd1 << 62) | (64'd1 << 60) | (64'd1 << 59);
        return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
    endfunction

    task automatic build_model(input logic [63:0] sd, input int n);
        logic [63:0] s, a, b;
        logic [4:0]  op;
        int          k;
        s = (sd == 64'd0) ? 64'd1 : sd;
        k = 0;
        for (int t = 0; t < 19; t++) begin
            op = optab[t];
            for (int i = 0; i < n; i++) begin
                if (i == 0) begin
                    a = '1;
                    b = 64'd1;
                end else begin
                    s = gal(s); a = s;
                    s = gal(s); b = s;
                end
                if (op == 5'h02 || op == 5'h04 || op == 5'h05) b = b % 64;
                if ((op == 5'h12 || op == 5'h14) && b == 64'd0) b = 64'd1;
                if (op == 5'h0B) a = 64'd0;
                exp_op[k] = op; exp_a[k] = a; exp_b[k] = b;
                k++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    int st_cyc  = 0;
    int ack_cyc = 0;

    // mode 0: ack tied high, 1: ack held low, 2: ack in the 6th WAIT_ACK cycle.
    task automatic do_run(input int mode, input logic [63:0] sd, input bit midstart, output int base);
        int  scnt;
        bit  acked;
        base   = nobs;
        seed0  = sd;
        ack0   = (mode == 0);
        start0 = 1'b1;
        st_cyc = cyc;
        @(negedge clk);
        start0 = 1'b0;
        scnt   = 0;
        acked  = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (sample0) scnt++; else scnt = 0;
            if (mode == 0) ack0 = 1'b1;
            else if (mode == 1) ack0 = 1'b0;
            else ack0 = (scnt == 6);
            if (ack0 && !acked) begin
                acked   = 1'b1;
                ack_cyc = cyc;
            end
            if (midstart && k == 20) begin
                start0 = 1'b1;
                seed0  = ~sd;
            end else begin
                start0 = 1'b0;
            end
            if (done0) break;
            @(negedge clk);
        end
        chk("done_seen", {63'd0, done0}, 64'd1);
        @(negedge clk);
        chk("done_one_cycle", {62'd0, done0, busy0}, 64'd0);
    endtask

    task automatic post_checks(input string nm, input logic [63:0] sd, input int base,
                               input int per, input logic exp_err, input int unst0);
        build_model(sd, 4);
        chk({nm, "_nvec"}, 64'(nobs - base), 64'd76);
        chk({nm, "_latency"}, 64'(obs_cyc[base] - st_cyc), 64'd1);
        for (int k = 0; k < 76; k++) begin
            chk($sformatf("%s_op[%0d]", nm, k), {59'd0, obs_op[base + k]}, {59'd0, exp_op[k]});
            chk($sformatf("%s_A[%0d]", nm, k), obs_a[base + k], exp_a[k]);
            chk($sformatf("%s_B[%0d]", nm, k), obs_b[base + k], exp_b[k]);
            if (k > 0)
                chk($sformatf("%s_period[%0d]", nm, k),
                    64'(obs_cyc[base + k] - obs_cyc[base + k - 1]), 64'(per));
        end
        chk({nm, "_vec_count"}, {48'd0, cnt0}, 64'd76);
        chk({nm, "_err_end"}, {63'd0, err0}, {63'd0, exp_err});
        chk({nm, "_err_first"}, {63'd0, obs_err[base]}, 64'd0);
        chk({nm, "_stable"}, 64'(unstable - unst0), 64'd0);
    endtask

    initial begin
        int          base, base_a, unst0, nd0;
        logic [63:0] s2, s3, s4, s5, s6;
        s2 = {$urandom, $urandom};
        s3 = {$urandom, $urandom};
        s4 = {$urandom, $urandom};
        s5 = {$urandom, $urandom};
        s6 = {$urandom, $urandom};

        rst_n  = 1'b0; srst = 1'b0;
        start0 = 1'b0; seed0 = 64'd0; ack0 = 1'b0;
        start1 = 1'b0; seed1 = 64'd0; ack1 = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_opcode", {59'd0, opcode0}, 64'h1F);
        chk("rst_A", A0, 64'd0);
        chk("rst_B", B0, 64'd0);
        chk("rst_flags", {59'd0, vv0, sample0, busy0, done0, err0}, 64'd0);
        chk("rst_count", {48'd0, cnt0}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: seed 0, ack tied high
        unst0 = unstable;
        do_run(0, 64'd0, 1'b0, base);
        post_checks("t1", 64'd0, base, 4, 1'b0, unst0);
        chk("t1_first_op", {59'd0, obs_op[base]}, 64'h00);
        chk("t1_first_A", obs_a[base], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_first_B", obs_b[base], 64'd1);

        // 2: ack held low -> every vector times out
        unst0 = unstable;
        do_run(1, s2, 1'b0, base);
        post_checks("t2", s2, base, 19, 1'b1, unst0);
        chk("t2_err_after_first", {63'd0, obs_err[base + 1]}, 64'd1);

        // 3: ack 5 cycles into WAIT_ACK
        unst0 = unstable;
        do_run(2, s3, 1'b0, base);
        post_checks("t3", s3, base, 9, 1'b0, unst0);
        chk("t3_ack_to_valid", 64'(obs_cyc[base + 1] - ack_cyc), 64'd1);

        // 5: reset at vector 10
        base   = nobs;
        seed0  = s5;
        ack0   = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (nobs - base >= 10) break;
            @(negedge clk);
        end
        chk("t5_reached10", {63'd0, (nobs - base >= 10)}, 64'd1);
        nd0 = ndone;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_opcode", {59'd0, opcode0}, 64'h1F);
        chk("t5_async_AB", A0 | B0, 64'd0);
        chk("t5_async_flags", {59'd0, vv0, sample0, busy0, done0, err0}, 64'd0);
        chk("t5_async_count", {48'd0, cnt0}, 64'd0);
        repeat (2) @(negedge clk);
        chk("t5_no_done", 64'(ndone - nd0), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        unst0 = unstable;
        do_run(0, s5, 1'b0, base);
        post_checks("t5", s5, base, 4, 1'b0, unst0);

        // 6: start while busy is ignored; rerun clears err and reproduces the stream
        unst0 = unstable;
        do_run(1, s6, 1'b1, base_a);
        post_checks("t6a", s6, base_a, 19, 1'b1, unst0);
        unst0 = unstable;
        do_run(0, s6, 1'b0, base);
        post_checks("t6b", s6, base, 4, 1'b0, unst0);

        // 4: N_PER_OP=2 instance
        build_model(s4, 2);
        seed1  = s4;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (done1) break;
            @(negedge clk);
        end
        chk("t4_done_seen", {63'd0, done1}, 64'd1);
        @(negedge clk);
        chk("t4_nvec", 64'(n1), 64'd38);
        chk("t4_vec_count", {48'd0, cnt1}, 64'd38);
        chk("t4_end_flags", {61'd0, busy1, err1, sample1}, 64'd0);
        for (int k = 0; k < 38; k++) begin
            chk($sformatf("t4_op[%0d]", k), {59'd0, o1_op[k]}, {59'd0, exp_op[k]});
            chk($sformatf("t4_A[%0d]", k), o1_a[k], exp_a[k]);
            chk($sformatf("t4_B[%0d]", k), o1_b[k], exp_b[k]);
            if (o1_op[k] == 5'h02 || o1_op[k] == 5'h04 || o1_op[k] == 5'h05)
                chk($sformatf("t4_shamt[%0d]", k), {63'd0, (o1_b[k] < 64'd64)}, 64'd1);
            if (o1_op[k] == 5'h12 || o1_op[k] == 5'h14)
                chk($sformatf("t4_divB[%0d]", k), {63'd0, (o1_b[k] != 64'd0)}, 64'd1);
            if (o1_op[k] == 5'h0B)
                chk($sformatf("t4_luiA[%0d]", k), o1_a[k], 64'd0);
        end
        chk("t4_after0E_a", {59'd0, o1_op[30]}, 64'h10);
        chk("t4_after0E_b", {59'd0, o1_op[32]}, 64'h11);
        chk("t4_after0E_c", {59'd0, o1_op[34]}, 64'h12);
        chk("t4_after0E_d", {59'd0, o1_op[36]}, 64'h14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
